// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg: shared definitions for the pattern transmitter.
//   state_t          FSM state encoding (PAR only with PATTERN_TX_PARITY_EN)
//   PATTERN_TX_WIDTH default maximum pattern length in bits
package pattern_tx_pkg;

    localparam int unsigned PATTERN_TX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef PATTERN_TX_PARITY_EN
        PAR   = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pattern_tx_piso.sv
// pattern_tx_piso: loadable, stallable parallel-in/serial-out shift register
// with a count of the bits still to be presented.
//   clk, rst    clock, asynchronous active-low reset
//   load        capture load_data/load_count
//   load_data   pattern, LSB first
//   load_count  number of bits in the pattern (1..WIDTH)
//   advance     consume the head bit
//   head        next bit to be presented
//   last        the bit currently being presented is the final one
module pattern_tx_piso #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CW-1:0]    load_count,
    input  logic             advance,
    output logic             head,
    output logic             last
);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    remaining;

    // Bit 0 is driven onto the serial line by the parent on the load edge,
    // so the register keeps only the bits still to come.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr        <= '0;
            remaining <= '0;
        end else if (load) begin
            sr        <= load_data >> 1;
            remaining <= load_count - CW'(1);
        end else if (advance) begin
            sr        <= sr >> 1;
            remaining <= remaining - CW'(1);
        end
    end

    assign head = sr[0];
    assign last = (remaining == '0);

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern transmitter, LSB first, with stall support.
// Optional feature macro: PATTERN_TX_PARITY_EN appends an even-parity bit.
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   start      transmit request, sampled only in IDLE
//   pattern    bits to send, latched on accepted start
//   nbits      bit count 1..WIDTH, latched on accepted start
//   stall      pause transmission, no bit consumed
//   outp       registered serial data
//   out_valid  outp carries a real bit
//   busy       high outside IDLE
//   done       one-cycle pulse after the final bit
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int unsigned WIDTH = PATTERN_TX_WIDTH,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CW-1:0]    nbits,
    input  logic             stall,
    output logic             outp,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    state_t state;
    logic   accept;
    logic   advance;
    logic   head;
    logic   last;

`ifdef PATTERN_TX_PARITY_EN
    logic   parity;
`endif

    assign accept  = (state == IDLE) && start &&
                     (nbits != '0) && (nbits <= CW'(WIDTH));
    assign advance = (state == SHIFT) && !stall && !last;

    pattern_tx_piso #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_piso (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_data  (pattern),
        .load_count (nbits),
        .advance    (advance),
        .head       (head),
        .last       (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            outp      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // First bit goes out on the accept edge.
                        state     <= SHIFT;
                        outp      <= pattern[0];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
`ifdef PATTERN_TX_PARITY_EN
                        parity    <= pattern[0];
`endif
                    end
                end
                SHIFT: begin
                    if (stall) begin
                        out_valid <= 1'b0;
                    end else if (!last) begin
                        outp      <= head;
                        out_valid <= 1'b1;
`ifdef PATTERN_TX_PARITY_EN
                        parity    <= parity ^ head;
`endif
                    end else begin
`ifdef PATTERN_TX_PARITY_EN
                        state     <= PAR;
                        outp      <= parity;
                        out_valid <= 1'b1;
`else
                        state     <= DONE;
                        outp      <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
`endif
                    end
                end
`ifdef PATTERN_TX_PARITY_EN
                PAR: begin
                    if (stall) begin
                        out_valid <= 1'b0;
                    end else begin
                        state     <= DONE;
                        outp      <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state     <= IDLE;
                    outp      <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    outp      <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
